// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the register write arbiter
package arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_e;

  function automatic int rr_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search from a start index
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int W = rr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     start,
  output logic             found,
  output logic [W-1:0]     winner
);

  logic [W-1:0] idx;

  // Scan start, start+1, ... modulo N_REQ; the first set bit wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = W'((int'(start) + i) % N_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin ownership of one shared D-register
module reg_write_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            we,
  input  logic [N_REQ-1:0][DW-1:0]    wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [rr_width(N_REQ)-1:0]  owner,
  output logic                        busy,
  output logic [DW-1:0]               q,
  output logic [DW-1:0]               qb
);

  localparam int W = rr_width(N_REQ);
  localparam logic [7:0]       HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);

  arb_state_e   state;
  logic [W-1:0] last_owner;
  logic [7:0]   hold_cnt;
  logic [W-1:0] start;
  logic         found;
  logic [W-1:0] winner;
  logic         release_now;

  // last_owner equals owner while BUSY, so one search start serves both paths.
  assign start       = (last_owner == W'(N_REQ - 1)) ? '0 : last_owner + W'(1);
  assign release_now = !req[owner] || (hold_cnt == HOLD_LAST);

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .start (start),
    .found (found),
    .winner(winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      owner      <= '0;
      last_owner <= W'(N_REQ - 1);
      hold_cnt   <= '0;
      q          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt        <= ONE << winner;
            owner      <= winner;
            last_owner <= winner;
            hold_cnt   <= '0;
            state      <= BUSY;
          end else begin
            gnt <= '0;
          end
        end
        BUSY: begin
          // The write in the final granted cycle still lands.
          if (we[owner]) q <= wdata[owner];
          if (release_now) begin
            if (found) begin
              gnt        <= ONE << winner;
              owner      <= winner;
              last_owner <= winner;
              hold_cnt   <= '0;
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = |gnt;
  assign qb   = ~q;

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter sharing one DW-bit D-register (storage flops plus `qb` inverse output) among N_REQ requesters. Each requester raises `req` to obtain exclusive write ownership of the register, optionally writes via `we`/`wdata` while granted, and is forcibly released after MAX_HOLD granted cycles so that no requester starves. It sits between independent producer blocks and a shared state/config register in the sequential-circuits library.

## Interface
- N_REQ, default 4: number of requesters, 2..16.
- DW, default 8: register data width.
- MAX_HOLD, default 4: maximum consecutive granted cycles per ownership, 1..255.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester ownership request, level.
- we  in  N_REQ  per-requester write enable, honoured only for the granted requester.
- wdata  in  N_REQ x DW  per-requester write data (packed array).
- gnt  out  N_REQ  one-hot-or-zero grant, registered.
- owner  out  $clog2(N_REQ)  index of the current grantee, valid while `busy`.
- busy  out  1  high while any grant is active.
- q  out  DW  shared register contents.
- qb  out  DW  always ~q, combinational.

## Operation
- Reset (async, asserted): gnt=0, busy=0, owner=0, q=0, qb=all-ones, hold_cnt=0, state=IDLE, last_owner=N_REQ-1, so requester 0 has top priority after reset.
- States: IDLE, BUSY.
- IDLE: if any req bit is set at the edge, pick the winner by round-robin search starting at last_owner+1 (mod N_REQ). Set gnt to one-hot(winner), owner=winner, last_owner=winner, hold_cnt=0, go to BUSY. Otherwise stay in IDLE with gnt=0.
- BUSY, at each edge:
  - Write: if we[owner] is high, q <= wdata[owner]; otherwise q holds. we/wdata from non-granted requesters are ignored.
  - Release occurs when req[owner] is low OR hold_cnt == MAX_HOLD-1.
  - On release, re-arbitrate in the same edge using the round-robin search from owner+1. The old owner has the lowest priority but is re-granted if it is still the only requester. If there is a winner: new gnt and owner, hold_cnt=0, stay in BUSY with no idle bubble. If there is no requester: gnt=0, busy=0, go to IDLE.
  - No release: hold_cnt increments and gnt is unchanged.
- A write and a release can happen in the same cycle. The write in the final granted cycle is always performed.
- gnt never has more than one bit set. busy == |gnt.

## Timing
- req to gnt latency: 1 cycle from IDLE. req sampled high at edge t gives gnt high after edge t.
- Write latency: we/wdata presented in a cycle with gnt high are captured at the next edge. q and qb are visible in the following cycle.
- Maximum ownership: MAX_HOLD consecutive cycles with gnt high.
- Worst-case wait for a continuously requesting requester: (N_REQ-1) x MAX_HOLD cycles.
- Dropping req: req low sampled at edge t means gnt drops (or moves to another requester) after edge t. A we asserted in that same cycle is still written.
- Reset mid-ownership: gnt, busy and q clear immediately and asynchronously. Arbitration restarts from requester 0 after rst deasserts.
- A req from an out-of-range or non-granted requester has no effect on q.

## Structure
- Shared package `arb_pkg` contains:
  - the state typedef `arb_state_e` {IDLE, BUSY};
  - the constant function `rr_width(n)` returning $clog2(n).
- Sub-module `rr_pick` is combinational and parameterised by N_REQ:
  - inputs: req vector, start index;
  - outputs: found and winner index.
  - It is instantiated once and shared by the IDLE and release paths.
- The storage register and `qb` inversion live in the top module.

## Test plan
- Reset: hold rst for 2 cycles with req=4'b1111 -> gnt=0, q=8'h00, qb=8'hFF. The first grant after release of reset goes to requester 0.
- Single requester: req[2]=1 for 3 cycles, with we[2]=1 and wdata[2]=8'hA5 in its first granted cycle -> gnt=4'b0100 for 3 cycles, then gnt=0 and busy=0. q=8'hA5 and qb=8'h5A one cycle after the write.
- Round-robin with timeout: req=4'b1111 held high, MAX_HOLD=4 -> owners in order 0,1,2,3,0, each holding for exactly 4 cycles with no idle cycle between them.
- Ignored write: owner 1 is granted, and we[3]=1 with wdata[3]=8'h3C is presented -> q is unchanged.
- Sole re-grant: req=4'b0010 held for 10 cycles with MAX_HOLD=4 -> gnt=4'b0010 continuously and hold_cnt restarts at cycles 4 and 8.
- Async reset mid-burst: rst is pulsed between edges while owner=2 and q=8'h77 -> gnt=0 and q=0 immediately. After rst deasserts with req=4'b0100, owner 2 is granted one cycle later.
